// File: rtl/gpu_wb_prim_assembler.sv
// Writeback-stage primitive assembler: collects SETVERTEX data into points, lines and
// triangles and queues them for the GPU stage. Define WB_STRIP_EN to enable triangle strips.
//
// state   | meaning
// IDLE    | no primitive open; vertex/end ops are protocol errors
// COLLECT | primitive open; vertices gathered into slots
module gpu_wb_prim_assembler #(
    parameter int VTX_W      = 30,
    parameter int COLOR_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               I_CLOCK,
    input  logic               I_LOCK,
    input  logic               I_Valid,
    input  logic [2:0]         I_Op,
    input  logic [1:0]         I_PrimType,
    input  logic [VTX_W-1:0]   I_VertexData,
    input  logic [COLOR_W-1:0] I_ColorData,
    input  logic               I_GPUStallSignal,
    output logic               O_Stall,
    output logic               O_PrimValid,
    output logic [1:0]         O_PrimType,
    output logic [VTX_W-1:0]   O_VertexV1,
    output logic [VTX_W-1:0]   O_VertexV2,
    output logic [VTX_W-1:0]   O_VertexV3,
    output logic [COLOR_W-1:0] O_PrimColor,
    output logic [15:0]        O_PrimCount,
    output logic               O_Err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] OP_BEGIN  = 3'd1;
    localparam logic [2:0] OP_VERTEX = 3'd2;
    localparam logic [2:0] OP_END    = 3'd3;
    localparam logic [2:0] OP_COLOR  = 3'd4;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t state_q, state_d;
    logic   err_set;

    logic [1:0]         type_q;
    logic [1:0]         vcnt_q;
    logic [1:0]         need_n;
    logic [VTX_W-1:0]   slot0_q, slot1_q;
    logic [COLOR_W-1:0] color_q;

    logic accept, is_begin, is_vtx, is_end, is_color;
    logic push, pop;

    logic [VTX_W-1:0] push_v1, push_v2, push_v3;
    logic [1:0]       push_type;

    logic [VTX_W-1:0]   mem_v1 [FIFO_DEPTH];
    logic [VTX_W-1:0]   mem_v2 [FIFO_DEPTH];
    logic [VTX_W-1:0]   mem_v3 [FIFO_DEPTH];
    logic [1:0]         mem_type [FIFO_DEPTH];
    logic [COLOR_W-1:0] mem_color [FIFO_DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [PW:0]        cnt_q;
    logic [15:0]        pcount_q;
    logic               err_q;

    assign O_Stall  = (cnt_q == CNT_FULL);
    assign accept   = I_Valid & ~O_Stall;
    assign is_begin = accept & (I_Op == OP_BEGIN);
    assign is_vtx   = accept & (I_Op == OP_VERTEX);
    assign is_end   = accept & (I_Op == OP_END);
    assign is_color = accept & (I_Op == OP_COLOR);

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_begin)             state_d = COLLECT;
                else if (is_vtx | is_end) err_set = 1'b1;
            end
            COLLECT: begin
                if (is_end)        state_d = IDLE;
                else if (is_begin) err_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (type_q)
            2'd0:    need_n = 2'd1;
            2'd1:    need_n = 2'd2;
            default: need_n = 2'd3;
        endcase
    end

    assign push = is_vtx & (state_q == COLLECT) & ((vcnt_q + 2'd1) == need_n);
    assign pop  = (cnt_q != '0) & ~I_GPUStallSignal;

    // Slots the primitive does not use are zero so consumers see clean vertices.
    always_comb begin
        push_v1   = '0;
        push_v2   = '0;
        push_v3   = '0;
        push_type = (type_q == 2'd3) ? 2'd2 : type_q;
        case (type_q)
            2'd0: push_v1 = I_VertexData;
            2'd1: begin
                push_v1 = slot0_q;
                push_v2 = I_VertexData;
            end
            default: begin
                push_v1 = slot0_q;
                push_v2 = slot1_q;
                push_v3 = I_VertexData;
            end
        endcase
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            type_q  <= 2'd0;
            vcnt_q  <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            color_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (err_set)  err_q   <= 1'b1;
            if (is_color) color_q <= I_ColorData;
            if (is_begin) begin
`ifdef WB_STRIP_EN
                type_q <= I_PrimType;
`else
                type_q <= (I_PrimType == 2'd3) ? 2'd2 : I_PrimType;
`endif
                vcnt_q <= 2'd0;
            end else if (is_end) begin
                vcnt_q <= 2'd0;
            end else if (is_vtx && state_q == COLLECT) begin
                if (push) begin
`ifdef WB_STRIP_EN
                    // Strip keeps the two newest vertices and stays one short of a triangle.
                    if (type_q == 2'd3) begin
                        slot0_q <= slot1_q;
                        slot1_q <= I_VertexData;
                    end else begin
                        vcnt_q <= 2'd0;
                    end
`else
                    vcnt_q <= 2'd0;
`endif
                end else begin
                    if (vcnt_q == 2'd0) slot0_q <= I_VertexData;
                    else                slot1_q <= I_VertexData;
                    vcnt_q <= vcnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (push) begin
            mem_v1[wptr_q]    <= push_v1;
            mem_v2[wptr_q]    <= push_v2;
            mem_v3[wptr_q]    <= push_v3;
            mem_type[wptr_q]  <= push_type;
            mem_color[wptr_q] <= color_q;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_LOCK) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            pcount_q <= 16'd0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q   <= rptr_q + 1'b1;
                pcount_q <= pcount_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign O_PrimValid = (cnt_q != '0);
    assign O_PrimType  = O_PrimValid ? mem_type[rptr_q]  : 2'd0;
    assign O_VertexV1  = O_PrimValid ? mem_v1[rptr_q]    : '0;
    assign O_VertexV2  = O_PrimValid ? mem_v2[rptr_q]    : '0;
    assign O_VertexV3  = O_PrimValid ? mem_v3[rptr_q]    : '0;
    assign O_PrimColor = O_PrimValid ? mem_color[rptr_q] : '0;
    assign O_PrimCount = pcount_q;
    assign O_Err       = err_q;

endmodule
